key_cond: RTL and testbench

KEY_COND -- requirements
Module: key_cond

---
 rtl/clock24_pkg.sv | 31 +++
 rtl/key_chan.sv | 133 +++++++++++++
 rtl/key_cond.sv | 37 +++
 tb/tb_key_cond.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock24_pkg.sv
// Shared constants and types for the clock24 design: clock-enable divisors,
// push-button timing defaults and the per-key auto-repeat state encoding.
package clock24_pkg;

    // System clock and the divider ratios that produce the 1 ms / 10 ms enables.
    localparam int CLK_HZ   = 100_000_000;
    localparam int CE1_DIV  = CLK_HZ / 1000;
    localparam int CE10_DIV = CLK_HZ / 100;

    // Button conditioning defaults, all counted in 1 ms enable ticks.
    localparam int DEB_MS_DEF     = 20;
    localparam int REP_DLY_MS_DEF = 500;
    localparam int REP_INT_MS_DEF = 100;

    // Auto-repeat state of one key.
    typedef enum logic [1:0] {
        KEY_IDLE   = 2'd0,
        KEY_DELAY  = 2'd1,
        KEY_REPEAT = 2'd2
    } key_state_e;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_chan.sv
// One push-button channel: 2-FF synchronizer, tick-based debounce and an
// IDLE/DELAY/REPEAT machine producing a press pulse plus optional auto-repeat.
module key_chan
    import clock24_pkg::*;
#(
    parameter int DEB_MS     = DEB_MS_DEF,
    parameter int REP_DLY_MS = REP_DLY_MS_DEF,
    parameter int REP_INT_MS = REP_INT_MS_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ce_i,
    input  logic key_i,
    input  logic rep_en_i,
    output logic lvl_o,
    output logic pls_o
);

    localparam int DEB_W = cnt_width(DEB_MS);
    localparam int REP_W = cnt_width(max2(REP_DLY_MS, REP_INT_MS));

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_MS - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REP_DLY_MS - 1);
    localparam logic [REP_W-1:0] INT_LAST = REP_W'(REP_INT_MS - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    logic             sync1_q;
    logic             sync_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             lvl_q, lvl_d;
    key_state_e       state_q, state_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             pls_q, pls_d;

    // Two-stage synchronizer: the raw button touches nothing else.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync_q  <= sync1_q;
        end
    end

    // Debounce: count ticks of disagreement, restart on any agreement, and
    // adopt the new level on the DEB_MS-th consecutive disagreeing tick.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        lvl_d     = lvl_q;
        if (sync_q == lvl_q) begin
            deb_cnt_d = '0;
        end else if (ce_i) begin
            if (deb_cnt_q == DEB_LAST) begin
                lvl_d     = sync_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_ONE;
            end
        end
    end

    // Repeat machine, driven by the next debounced level so the press pulse
    // lands in the same cycle the level first reads high and a release beats
    // any repeat that falls due on the same tick.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        pls_d     = 1'b0;
        if (!lvl_d) begin
            state_d   = KEY_IDLE;
            rep_cnt_d = '0;
        end else begin
            case (state_q)
                KEY_IDLE: begin
                    state_d   = KEY_DELAY;
                    rep_cnt_d = '0;
                    pls_d     = 1'b1;
                end
                KEY_DELAY: begin
                    if (ce_i) begin
                        if (rep_cnt_q == DLY_LAST) begin
                            // Without repeat enable the counter parks here.
                            if (rep_en_i) begin
                                state_d   = KEY_REPEAT;
                                rep_cnt_d = '0;
                                pls_d     = 1'b1;
                            end
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_ONE;
                        end
                    end
                end
                KEY_REPEAT: begin
                    if (ce_i) begin
                        if (rep_cnt_q == INT_LAST) begin
                            rep_cnt_d = '0;
                            pls_d     = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_ONE;
                        end
                    end
                end
                default: begin
                    state_d   = KEY_IDLE;
                    rep_cnt_d = '0;
                end
            endcase
        end
    end

    // Debounce and repeat state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            deb_cnt_q <= '0;
            lvl_q     <= 1'b0;
            state_q   <= KEY_IDLE;
            rep_cnt_q <= '0;
            pls_q     <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            lvl_q     <= lvl_d;
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            pls_q     <= pls_d;
        end
    end

    assign lvl_o = lvl_q;
    assign pls_o = pls_q;

endmodule

// File: rtl/key_cond.sv
// Push-button conditioner between the board buttons and counter24: one
// independent key_chan per button, all timed by the 1 ms clock enable.
module key_cond
    import clock24_pkg::*;
#(
    parameter int N_KEY      = 3,
    parameter int DEB_MS     = DEB_MS_DEF,
    parameter int REP_DLY_MS = REP_DLY_MS_DEF,
    parameter int REP_INT_MS = REP_INT_MS_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [N_KEY-1:0] KEY_IN,
    input  logic [N_KEY-1:0] REP_EN,
    output logic [N_KEY-1:0] KEY_LVL,
    output logic [N_KEY-1:0] KEY_PLS
);

    // One fully independent channel per button.
    for (genvar gi = 0; gi < N_KEY; gi++) begin : g_chan
        key_chan #(
            .DEB_MS     (DEB_MS),
            .REP_DLY_MS (REP_DLY_MS),
            .REP_INT_MS (REP_INT_MS)
        ) u_chan (
            .clk_i    (CLK),
            .rst_i    (RST),
            .ce_i     (CE),
            .key_i    (KEY_IN[gi]),
            .rep_en_i (REP_EN[gi]),
            .lvl_o    (KEY_LVL[gi]),
            .pls_o    (KEY_PLS[gi])
        );
    end

endmodule

// File: tb/tb_key_cond.sv
// Bench for key_cond: directed button scenarios followed by random button
// activity, each tick compared against a tick-level reference model.
module tb_key_cond;

    localparam int NK  = 3;
    localparam int DEB = 20;
    localparam int DLY = 50;
    localparam int INT = 10;

    logic          CLK;
    logic          RST;
    logic          CE;
    logic [NK-1:0] KEY_IN;
    logic [NK-1:0] REP_EN;
    logic [NK-1:0] KEY_LVL;
    logic [NK-1:0] KEY_PLS;

    key_cond #(
        .N_KEY      (NK),
        .DEB_MS     (DEB),
        .REP_DLY_MS (DLY),
        .REP_INT_MS (INT)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .CE      (CE),
        .KEY_IN  (KEY_IN),
        .REP_EN  (REP_EN),
        .KEY_LVL (KEY_LVL),
        .KEY_PLS (KEY_PLS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: raw sample history per key, debounced level, press tick.
    logic [NK-1:0]  lvl_m;
    logic [DEB-1:0] hist_m [NK];
    int             t0_m [NK];
    int             tick_n = 0;

    // Observations gathered per scenario.
    int cnt_pls [NK];
    int first_pls [NK];
    int first_lvl [NK];
    int base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, exp, tick_n);
        end
    endtask

    task automatic model_reset();
        lvl_m = '0;
        for (int k = 0; k < NK; k++) begin
            hist_m[k] = '0;
            t0_m[k]   = 0;
        end
    endtask

    task automatic begin_scn();
        base = tick_n;
        for (int k = 0; k < NK; k++) begin
            cnt_pls[k]   = 0;
            first_pls[k] = -1;
            first_lvl[k] = -1;
        end
    endtask

    // One 1 ms tick: apply raw levels right after the previous enable edge,
    // run three plain cycles then one enable cycle, then compare.
    task automatic do_tick(input logic [NK-1:0] keys);
        logic [NK-1:0] exp_pls;
        int d;
        KEY_IN = keys;
        CE     = 1'b0;
        @(posedge CLK); #1;
        chk("pls_off_ce", KEY_PLS, '0);
        @(posedge CLK);
        @(posedge CLK); #1;
        CE = 1'b1;
        @(posedge CLK); #1;
        CE = 1'b0;
        tick_n++;
        exp_pls = '0;
        for (int k = 0; k < NK; k++) begin
            hist_m[k] = {hist_m[k][DEB-2:0], keys[k]};
            if (!lvl_m[k] && (&hist_m[k])) begin
                lvl_m[k]   = 1'b1;
                t0_m[k]    = tick_n;
                exp_pls[k] = 1'b1;
            end else if (lvl_m[k] && !(|hist_m[k])) begin
                lvl_m[k] = 1'b0;
            end else if (lvl_m[k] && REP_EN[k]) begin
                d = tick_n - t0_m[k];
                if (d >= DLY && ((d - DLY) % INT) == 0) exp_pls[k] = 1'b1;
            end
        end
        chk("lvl", KEY_LVL, lvl_m);
        chk("pls", KEY_PLS, exp_pls);
        for (int k = 0; k < NK; k++) begin
            if (KEY_PLS[k]) begin
                cnt_pls[k]++;
                if (first_pls[k] < 0) first_pls[k] = tick_n;
            end
            if (KEY_LVL[k] && first_lvl[k] < 0) first_lvl[k] = tick_n;
        end
    endtask

    // Reset pulse in the middle of a tick while buttons keep their levels.
    task automatic pulse_reset();
        #2;
        RST = 1'b1;
        #1;
        chk("rst_now_lvl", KEY_LVL, '0);
        chk("rst_now_pls", KEY_PLS, '0);
        @(posedge CLK);
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
    endtask

    int            run_left [NK];
    logic [NK-1:0] cur;

    initial begin
        RST    = 1'b1;
        CE     = 1'b0;
        KEY_IN = '0;
        REP_EN = 3'b011;
        model_reset();
        begin_scn();

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_lvl", KEY_LVL, '0);
        chk("reset_pls", KEY_PLS, '0);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("post_reset_lvl", KEY_LVL, '0);
        chk("post_reset_pls", KEY_PLS, '0);
        $display("reset: outputs low");

        // Clean press on key 0: level rises on the 20th high tick.
        begin_scn();
        repeat (40) do_tick(3'b001);
        repeat (30) do_tick(3'b000);
        chk("clean_rise_tick", first_lvl[0] - base, 20);
        chk("clean_pulses", cnt_pls[0], 1);
        $display("clean press: pulses=%0d rise=%0d", cnt_pls[0], first_lvl[0] - base);

        // Bounce: five toggles three ticks apart, last toggle (to high) at
        // tick 13, so the 20th stable high tick is tick 32.
        begin_scn();
        repeat (3) do_tick(3'b001);
        repeat (3) do_tick(3'b000);
        repeat (3) do_tick(3'b001);
        repeat (3) do_tick(3'b000);
        repeat (40) do_tick(3'b001);
        repeat (30) do_tick(3'b000);
        chk("bounce_rise_tick", first_lvl[0] - base, 32);
        chk("bounce_pulses", cnt_pls[0], 1);
        $display("bounce: pulses=%0d rise=%0d", cnt_pls[0], first_lvl[0] - base);

        // Long hold with repeat: press, +50, then every 10 until release.
        begin_scn();
        repeat (200) do_tick(3'b010);
        repeat (30) do_tick(3'b000);
        chk("repeat_pulses", cnt_pls[1], 16);
        $display("hold with repeat: pulses=%0d", cnt_pls[1]);

        // Same hold with repeat disabled: a single press pulse.
        begin_scn();
        repeat (200) do_tick(3'b100);
        repeat (30) do_tick(3'b000);
        chk("norepeat_pulses", cnt_pls[2], 1);
        $display("hold without repeat: pulses=%0d", cnt_pls[2]);

        // Level falls exactly when the second repeat would be due.
        begin_scn();
        repeat (60) do_tick(3'b001);
        repeat (30) do_tick(3'b000);
        chk("release_on_due_pulses", cnt_pls[0], 2);
        chk("release_on_due_lvl", KEY_LVL[0], 1'b0);
        $display("release on due tick: pulses=%0d", cnt_pls[0]);

        // Reset in REPEAT right after a repeat pulse, key still held.
        begin_scn();
        repeat (80) do_tick(3'b010);
        chk("pre_reset_pulses", cnt_pls[1], 3);
        chk("pre_reset_pls_now", KEY_PLS[1], 1'b1);
        pulse_reset();
        begin_scn();
        repeat (40) do_tick(3'b010);
        chk("rst_repress_tick", first_pls[1] - base, 20);
        chk("rst_repress_pulses", cnt_pls[1], 1);
        repeat (30) do_tick(3'b000);
        $display("reset mid repeat: first pulse after release at tick %0d", first_pls[1] - base);

        // Simultaneous presses on all keys.
        begin_scn();
        repeat (30) do_tick(3'b111);
        repeat (30) do_tick(3'b000);
        for (int k = 0; k < NK; k++) begin
            chk("simul_tick", first_pls[k] - base, 20);
            chk("simul_pulses", cnt_pls[k], 1);
        end
        $display("simultaneous: pulse ticks %0d %0d %0d", first_pls[0] - base,
                 first_pls[1] - base, first_pls[2] - base);

        // Random button activity with random repeat enables.
        begin_scn();
        REP_EN = NK'($urandom);
        cur    = '0;
        for (int k = 0; k < NK; k++) run_left[k] = int'($urandom_range(1, 80));
        for (int t = 0; t < 800; t++) begin
            for (int k = 0; k < NK; k++) begin
                if (run_left[k] == 0) begin
                    cur[k]      = ~cur[k];
                    run_left[k] = int'($urandom_range(1, 80));
                end
                run_left[k]--;
            end
            do_tick(cur);
        end
        repeat (30) do_tick(3'b000);
        $display("random: rep_en=%b pulses=%0d %0d %0d", REP_EN, cnt_pls[0], cnt_pls[1], cnt_pls[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
